uart_stream: RTL

Single-clock, parametrised UART engine: one TX and one RX channel with per-frame configurable data bits, parity and stop bits, plus a 16x-oversampled receiver with majority-vote sampling, false-start rejection and framing/parity/overrun reporting. It replaces divided-clock UART datapaths with clock-enable ticks, so no clock-domain-crossing handshakes are needed. It sits between a peripheral's packet split/combine logic and the `in[0]`/`out[0]` pins. Config inputs come from the peripheral's generic config registers.

---
 rtl/uart_stream_pkg.sv | 13 +
 rtl/uart_stream_if.sv | 22 ++
 rtl/uart_stream.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_pkg.sv
// Shared configuration types for the UART stream engine.
package uart_stream_pkg;
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic {
        STOP_BITS_1 = 1'b0,
        STOP_BITS_2 = 1'b1
    } stop_bits_t;
endpackage

// File: rtl/uart_stream_if.sv
// Character-level TX/RX handshake bundle between peripheral logic (master) and the UART engine (slave).
interface uart_stream_if #(parameter int DATA_W = 9);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_frame_err;
    logic              rx_parity_err;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_stream.sv
// UART TX + 16x-oversampled RX on clock-enable ticks; tx drops 1 clk after accept, rx_valid ~3 clks after stop mid-point.
// TX accepts only when idle; RX holds one character and drops (rx_overrun) new ones while it is unread.
module uart_stream
    import uart_stream_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CLK_DIV_W-1:0] cfg_clk_div,
    input  logic [3:0]           cfg_data_bits,
    input  parity_t              cfg_parity,
    input  stop_bits_t           cfg_stop_bits,
    uart_stream_if.slave         strm,
    output logic                 tx,
    input  logic                 rx,
    output logic                 idle
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_MID_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_MID_P1 = OS_W'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        if (n < 4'd5)             return 4'd5;
        else if (int'(n) > DATA_W) return 4'(DATA_W);
        else                       return n;
    endfunction

    function automatic logic [DATA_W-1:0] bits_mask(input logic [3:0] n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    // ---------------- TX ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [CLK_DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic [3:0]           tx_bit_q, tx_bit_d, tx_nbits_q, tx_nbits_d;
    logic [DATA_W-1:0]    tx_shift_q, tx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_pbit_q, tx_pbit_d;
    logic                 tx_stop2_q, tx_stop2_d, tx_q, tx_d;
    logic                 tx_bit_end;
    logic [3:0]           tx_nb_cfg;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_div_d    = tx_div_q;
        tx_os_d     = tx_os_q;
        tx_bit_d    = tx_bit_q;
        tx_nbits_d  = tx_nbits_q;
        tx_shift_d  = tx_shift_q;
        tx_par_en_d = tx_par_en_q;
        tx_pbit_d   = tx_pbit_q;
        tx_stop2_d  = tx_stop2_q;
        tx_d        = tx_q;
        tx_bit_end  = 1'b0;
        tx_nb_cfg   = clamp_bits(cfg_data_bits);

        if (tx_state_q == ST_IDLE) begin
            tx_d = 1'b1;
            if (strm.tx_valid) begin
                tx_state_d  = ST_START;
                tx_d        = 1'b0;
                tx_cnt_d    = cfg_clk_div;
                tx_div_d    = cfg_clk_div;
                tx_os_d     = '0;
                tx_bit_d    = '0;
                tx_nbits_d  = tx_nb_cfg;
                tx_shift_d  = strm.tx_data;
                tx_par_en_d = (cfg_parity == PARITY_EVEN) || (cfg_parity == PARITY_ODD);
                tx_pbit_d   = (^(strm.tx_data & bits_mask(tx_nb_cfg))) ^ (cfg_parity == PARITY_ODD);
                tx_stop2_d  = (cfg_stop_bits == STOP_BITS_2);
            end
        end else if (tx_cnt_q == '0) begin
            tx_cnt_d = tx_div_q;
            if (tx_os_q == OS_LAST) begin
                tx_os_d    = '0;
                tx_bit_end = 1'b1;
            end else begin
                tx_os_d = tx_os_q + 1'b1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end

        if (tx_bit_end) begin
            case (tx_state_q)
                ST_START: begin
                    tx_state_d = ST_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = '0;
                end
                ST_DATA: begin
                    if (tx_bit_q == tx_nbits_q - 4'd1) begin
                        tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
                        tx_d       = tx_par_en_q ? tx_pbit_q : 1'b1;
                        tx_bit_d   = '0;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    tx_state_d = ST_STOP;
                    tx_d       = 1'b1;
                    tx_bit_d   = '0;
                end
                ST_STOP: begin
                    if (tx_stop2_q && (tx_bit_q == 4'd0)) tx_bit_d = 4'd1;
                    else                                  tx_state_d = ST_IDLE;
                end
                default: begin
                    tx_state_d = ST_IDLE;
                    tx_d       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= '0;
            tx_os_q     <= '0;
            tx_bit_q    <= '0;
            tx_nbits_q  <= '0;
            tx_shift_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_pbit_q   <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_os_q     <= tx_os_d;
            tx_bit_q    <= tx_bit_d;
            tx_nbits_q  <= tx_nbits_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_en_q <= tx_par_en_d;
            tx_pbit_q   <= tx_pbit_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_q        <= tx_d;
        end
    end

    assign tx            = tx_q;
    assign strm.tx_ready = (tx_state_q == ST_IDLE);

    // ---------------- RX ----------------
    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CLK_DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic [3:0]           rx_bit_q, rx_bit_d, rx_nbits_q, rx_nbits_d;
    logic [DATA_W-1:0]    rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
    logic                 rx_acc_q, rx_acc_d, rx_perr_q, rx_perr_d;
    logic                 rx_v0_q, rx_v0_d, rx_v1_q, rx_v1_d;
    logic [DATA_W-1:0]    rx_hold_q, rx_hold_d;
    logic                 rx_ferr_q, rx_ferr_d, rx_hperr_q, rx_hperr_d;
    logic                 rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic                 rx_maj, rx_at_mid, rx_at_vote, rx_bit_end, rx_done, rx_stop_bad;

    assign rx_maj = (rx_v0_q & rx_v1_q) | (rx_v0_q & rx_s2_q) | (rx_v1_q & rx_s2_q);

    always_comb begin
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_s3_d     = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_os_d     = rx_os_q;
        rx_bit_d    = rx_bit_q;
        rx_nbits_d  = rx_nbits_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_acc_d    = rx_acc_q;
        rx_perr_d   = rx_perr_q;
        rx_v0_d     = rx_v0_q;
        rx_v1_d     = rx_v1_q;
        rx_hold_d   = rx_hold_q;
        rx_ferr_d   = rx_ferr_q;
        rx_hperr_d  = rx_hperr_q;
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = 1'b0;
        rx_at_mid   = 1'b0;
        rx_at_vote  = 1'b0;
        rx_bit_end  = 1'b0;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;

        if (rx_state_q == ST_IDLE) begin
            if (rx_s3_q && !rx_s2_q) begin
                rx_state_d = ST_START;
                rx_cnt_d   = cfg_clk_div;
                rx_div_d   = cfg_clk_div;
                rx_os_d    = '0;
            end
        end else if (rx_cnt_q == '0) begin
            rx_cnt_d = rx_div_q;
            if (rx_os_q == OS_LAST) begin
                rx_os_d    = '0;
                rx_bit_end = 1'b1;
            end else begin
                rx_os_d = rx_os_q + 1'b1;
            end
            if (rx_os_q == OS_MID_M1) rx_v0_d = rx_s2_q;
            if (rx_os_q == OS_MID) begin
                rx_v1_d   = rx_s2_q;
                rx_at_mid = 1'b1;
            end
            if (rx_os_q == OS_MID_P1) rx_at_vote = 1'b1;
        end else begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end

        case (rx_state_q)
            ST_IDLE: ;
            ST_START: begin
                if (rx_at_mid) begin
                    if (rx_s2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_nbits_d  = clamp_bits(cfg_data_bits);
                        rx_par_en_d = (cfg_parity == PARITY_EVEN) || (cfg_parity == PARITY_ODD);
                        rx_odd_d    = (cfg_parity == PARITY_ODD);
                        rx_shift_d  = '0;
                        rx_bit_d    = '0;
                        rx_acc_d    = 1'b0;
                        rx_perr_d   = 1'b0;
                    end
                end else if (rx_bit_end) begin
                    rx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_at_vote) begin
                    rx_shift_d[rx_bit_q] = rx_maj;
                    rx_acc_d             = rx_acc_q ^ rx_maj;
                    rx_bit_d             = rx_bit_q + 4'd1;
                end
                if (rx_bit_end && (rx_bit_q == rx_nbits_q))
                    rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                // Data+parity XOR is 0 for even, 1 for odd when the frame is good.
                if (rx_at_vote) rx_perr_d = rx_acc_q ^ rx_maj ^ rx_odd_q;
                if (rx_bit_end) rx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (rx_at_vote) begin
                    rx_stop_bad = ~rx_maj;
                    rx_done     = 1'b1;
                    rx_state_d  = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase

        if (rx_valid_q && strm.rx_ready) rx_valid_d = 1'b0;
        if (rx_done) begin
            if (!rx_valid_q || strm.rx_ready) begin
                rx_valid_d = 1'b1;
                rx_hold_d  = rx_shift_q;
                rx_ferr_d  = rx_stop_bad;
                rx_hperr_d = rx_perr_q;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= '0;
            rx_os_q     <= '0;
            rx_bit_q    <= '0;
            rx_nbits_q  <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_acc_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_v0_q     <= 1'b1;
            rx_v1_q     <= 1'b1;
            rx_hold_q   <= '0;
            rx_ferr_q   <= 1'b0;
            rx_hperr_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_s3_q     <= rx_s3_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_os_q     <= rx_os_d;
            rx_bit_q    <= rx_bit_d;
            rx_nbits_q  <= rx_nbits_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_acc_q    <= rx_acc_d;
            rx_perr_q   <= rx_perr_d;
            rx_v0_q     <= rx_v0_d;
            rx_v1_q     <= rx_v1_d;
            rx_hold_q   <= rx_hold_d;
            rx_ferr_q   <= rx_ferr_d;
            rx_hperr_q  <= rx_hperr_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
        end
    end

    assign strm.rx_data       = rx_hold_q;
    assign strm.rx_frame_err  = rx_ferr_q;
    assign strm.rx_parity_err = rx_hperr_q;
    assign strm.rx_valid      = rx_valid_q;
    assign strm.rx_overrun    = rx_ovr_q;

    assign idle = (tx_state_q == ST_IDLE) && (rx_state_q == ST_IDLE) && !rx_valid_q;
endmodule
